nport_router: RTL and testbench
===============================

NPORT_ROUTER -- requirements
Module: nport_router

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16, meaning flit width in bits (minimum 4).
REQ-002 The module SHALL have parameter NUM_IN, default 4, meaning input port count (2..8).
REQ-003 The module SHALL have parameter DEPTH, default 4, meaning entries per class FIFO (power of two, at least 2).
REQ-004 The module SHALL have parameter PRIO_HEAD, default 3'b001, meaning head code that marks a priority flit.
REQ-005 The module SHALL have parameter STARVE_LIMIT, default 4, meaning consecutive priority sends before one regular send is forced (at least 1).
REQ-006 The module SHALL have one clock; reset is synchronous and active-high; the ports are named clk and reset.
REQ-007 The module SHALL have port clk, input, width 1: rising-edge clock.
REQ-008 The module SHALL have port reset, input, width 1: synchronous active-high reset.
REQ-009 The module SHALL have port input_data, input, width NUM_IN*WIDTH: port i occupies bits [i*WIDTH +: WIDTH]; the head code is the top 3 bits of each port slice.
REQ-010 The module SHALL have port input_req, input, width NUM_IN: per-port flit valid.
REQ-011 The module SHALL have port input_bussy, output, width NUM_IN: per-port stall.
REQ-012 The module SHALL have port output_data, output, width WIDTH: flit at the head of the selected FIFO.
REQ-013 The module SHALL have port output_req, output, width 1: output flit valid.
REQ-014 The module SHALL have port output_bussy, input, width 1: downstream stall.
REQ-015 The module SHALL have port prio_count, output, width clog2(DEPTH+1): priority FIFO occupancy.
REQ-016 The module SHALL have port reg_count, output, width clog2(DEPTH+1): regular FIFO occupancy.

Function
REQ-017 The module SHALL classify a flit as priority when its head equals PRIO_HEAD, and as regular for any other head.
REQ-018 The module SHALL contain two FIFOs, priority and regular, each DEPTH x WIDTH, show-ahead read (head entry visible without a read), with no write-to-read bypass.
REQ-019 The module SHALL accept at most one flit per class per cycle; the write occurs at the clock edge.
REQ-020 The module SHALL arbitrate each class round-robin: among ports requesting that class, grant the first index after that class's last-granted pointer, cyclically.
REQ-021 The module SHALL grant no port of a class while that class's FIFO is full, including cycles with a simultaneous read of that FIFO.
REQ-022 The module SHALL move a class's last-granted pointer to the granted index only on a cycle where a flit of that class is accepted.
REQ-023 The module SHALL drive input_bussy[i] = input_req[i] AND NOT grant[i] (combinational); a flit is accepted on an edge where input_req[i]=1 and input_bussy[i]=0.
REQ-024 The module SHALL drive output_req=1 whenever either FIFO is non-empty.
REQ-025 The module SHALL select the regular FIFO if and only if (priority FIFO empty) OR (starve_cnt equals STARVE_LIMIT AND regular FIFO non-empty); otherwise it SHALL select the priority FIFO.
REQ-026 The module SHALL drive output_data from the selected FIFO head.
REQ-027 The module SHALL pop the selected FIFO on an edge where output_req=1 and output_bussy=0.
REQ-028 The module SHALL increment starve_cnt, saturating at STARVE_LIMIT, on a priority pop while the regular FIFO is non-empty.
REQ-029 The module SHALL clear starve_cnt on any regular pop, and hold it otherwise.
REQ-030 The module SHALL support a same-cycle push and pop on one FIFO: occupancy unchanged, and order preserved.
REQ-031 The module SHALL treat occupancy arithmetic as modulo-DEPTH pointer wrap with an explicit count; prio_count and reg_count SHALL never exceed DEPTH.
REQ-032 The module SHALL give ordering guarantees only within a class; priority flits may overtake regular flits.

Reset
REQ-033 The module SHALL, while reset=1, clear both FIFO pointers and counts, both round-robin pointers (last-granted = NUM_IN-1, so port 0 wins first) and starve_cnt.
REQ-034 The module SHALL, while reset=1, force input_bussy to all ones and output_req to 0, and perform no push or pop.
REQ-035 The module SHALL hold output_data at X-free 0 after reset until the first push.
REQ-036 The module SHALL discard any in-flight FIFO contents when reset is asserted mid-operation, with no flit emitted afterwards.

Verification
REQ-037 The bench SHALL cover: ports 0..3 all send regular flits (head 000) continuously with output_bussy=0 -> grants go 0,1,2,3,0 and output order matches.
REQ-038 The bench SHALL cover: port 1 sends priority 0x2AAA and port 2 sends regular 0x0555 in the same cycle -> both accepted, and output shows 0x2AAA then 0x0555.
REQ-039 The bench SHALL cover: output_bussy=1 while port 0 pushes 5 regular flits with DEPTH=4 -> reg_count=4, input_bussy[0]=1 on the 5th, and the 5th is accepted the cycle after the first pop.
REQ-040 The bench SHALL cover: priority and regular FIFOs both kept non-empty with STARVE_LIMIT=4 -> the output pattern is 4 priority, 1 regular, repeating.
REQ-041 The bench SHALL cover: reset asserted for 1 cycle with prio_count=3 -> the next cycle shows prio_count=0, output_req=0, and round-robin restarting at port 0.
REQ-042 The bench SHALL cover: a simultaneous push and pop on a full FIFO -> push refused (input_bussy=1), pop occurs, and the count drops to DEPTH-1.

Source files
------------

// File: rtl/nport_router.sv
// N-port to 1 flit router: two class FIFOs (priority / regular) fed by per-class
// round-robin arbiters, drained through a starvation-limited priority selector.
module nport_router #(
  parameter int         WIDTH        = 16,
  parameter int         NUM_IN       = 4,
  parameter int         DEPTH        = 4,
  parameter logic [2:0] PRIO_HEAD    = 3'b001,
  parameter int         STARVE_LIMIT = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_IN*WIDTH-1:0]     input_data,
  input  logic [NUM_IN-1:0]           input_req,
  output logic [NUM_IN-1:0]           input_bussy,
  output logic [WIDTH-1:0]            output_data,
  output logic                        output_req,
  input  logic                        output_bussy,
  output logic [$clog2(DEPTH+1)-1:0]  prio_count,
  output logic [$clog2(DEPTH+1)-1:0]  reg_count
);

  localparam int CW  = $clog2(DEPTH + 1);
  localparam int PW  = $clog2(DEPTH);
  localparam int IW  = $clog2(NUM_IN);
  localparam int SW  = $clog2(STARVE_LIMIT + 1);
  localparam int REG = 0;
  localparam int PRI = 1;

  logic [WIDTH-1:0]  mem [2][DEPTH];
  logic [PW-1:0]     wr_ptr [2];
  logic [PW-1:0]     rd_ptr [2];
  logic [CW-1:0]     count [2];
  logic [IW-1:0]     last [2];
  logic [SW-1:0]     starve_cnt;

  logic [NUM_IN-1:0] class_req [2];
  logic [NUM_IN-1:0] grant [2];
  logic [IW-1:0]     grant_idx [2];
  logic [WIDTH-1:0]  wdata [2];
  logic [1:0]        push, pop, full, empty;
  logic              sel_reg;

  always_comb begin
    for (int i = 0; i < NUM_IN; i++) begin
      class_req[PRI][i] = input_req[i] && (input_data[i*WIDTH + WIDTH - 3 +: 3] == PRIO_HEAD);
      class_req[REG][i] = input_req[i] && (input_data[i*WIDTH + WIDTH - 3 +: 3] != PRIO_HEAD);
    end
    for (int c = 0; c < 2; c++) begin
      full[c]  = (count[c] == CW'(DEPTH));
      empty[c] = (count[c] == '0);
    end
  end

  // Round robin: first pass searches indices above the last grant, second pass
  // wraps around to indices at or below it.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the block leaves it unassigned, which would infer a latch.
    for (int c = 0; c < 2; c++) begin
      grant[c]     = '0;
      grant_idx[c] = last[c];
      push[c]      = 1'b0;
      wdata[c]     = '0;
      if (!reset && !full[c]) begin
        for (int i = 0; i < NUM_IN; i++) begin
          if (!push[c] && class_req[c][i] && (IW'(i) > last[c])) begin
            grant[c][i]  = 1'b1;
            grant_idx[c] = IW'(i);
            push[c]      = 1'b1;
            wdata[c]     = input_data[i*WIDTH +: WIDTH];
          end
        end
        for (int i = 0; i < NUM_IN; i++) begin
          if (!push[c] && class_req[c][i] && (IW'(i) <= last[c])) begin
            grant[c][i]  = 1'b1;
            grant_idx[c] = IW'(i);
            push[c]      = 1'b1;
            wdata[c]     = input_data[i*WIDTH +: WIDTH];
          end
        end
      end
    end
  end

  assign input_bussy = reset ? '1 : (input_req & ~(grant[PRI] | grant[REG]));

  always_comb begin
    sel_reg    = empty[PRI] || ((starve_cnt == SW'(STARVE_LIMIT)) && !empty[REG]);
    output_req = !reset && !(empty[PRI] && empty[REG]);
    pop[REG]   = output_req && !output_bussy && sel_reg;
    pop[PRI]   = output_req && !output_bussy && !sel_reg;
    // Gating on output_req keeps the never-written storage from showing as X.
    if (!output_req)  output_data = '0;
    else if (sel_reg) output_data = mem[REG][rd_ptr[REG]];
    else              output_data = mem[PRI][rd_ptr[PRI]];
  end

  assign prio_count = count[PRI];
  assign reg_count  = count[REG];

  // NOTE: storage is deliberately left out of reset; the pointers and counts
  // define which entries are valid, so clearing the array buys nothing.
  always_ff @(posedge clk) begin
    for (int c = 0; c < 2; c++)
      if (push[c]) mem[c][wr_ptr[c]] <= wdata[c];
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge values of the others regardless of order.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < 2; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
        count[c]  <= '0;
        last[c]   <= IW'(NUM_IN - 1);
      end
      starve_cnt <= '0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (push[c]) begin
          wr_ptr[c] <= wr_ptr[c] + 1'b1;
          last[c]   <= grant_idx[c];
        end
        if (pop[c]) rd_ptr[c] <= rd_ptr[c] + 1'b1;
        count[c] <= count[c] + CW'(push[c]) - CW'(pop[c]);
      end
      if (pop[REG])
        starve_cnt <= '0;
      else if (pop[PRI] && !empty[REG] && (starve_cnt != SW'(STARVE_LIMIT)))
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_nport_router.sv
// Directed bench for nport_router: a per-cycle vector table plus hand-written
// sequences for starvation and mid-operation reset.
module tb_nport_router;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] input_data;
  logic [3:0]  input_req;
  logic [3:0]  input_bussy;
  logic [15:0] output_data;
  logic        output_req;
  logic        output_bussy;
  logic [2:0]  prio_count;
  logic [2:0]  reg_count;

  nport_router #(
    .WIDTH(16), .NUM_IN(4), .DEPTH(4), .PRIO_HEAD(3'b001), .STARVE_LIMIT(4)
  ) dut (
    .clk(clk), .reset(reset),
    .input_data(input_data), .input_req(input_req), .input_bussy(input_bussy),
    .output_data(output_data), .output_req(output_req), .output_bussy(output_bussy),
    .prio_count(prio_count), .reg_count(reg_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] d0, d1, d2, d3;
    logic        obusy;
    logic [3:0]  e_ibusy;
    logic        e_oreq;
    logic [15:0] e_odata;
    logic [2:0]  e_pc;
    logic [2:0]  e_rc;
  } vec_t;

  vec_t vecs[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] rq, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] c, input logic [15:0] d,
                       input logic ob);
    reset        = r;
    input_req    = rq;
    input_data   = {d, c, b, a};
    output_bussy = ob;
  endtask

  task automatic add(input string nm, input logic r, input logic [3:0] rq,
                     input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                     input logic [15:0] d, input logic ob, input logic [3:0] eb,
                     input logic eo, input logic [15:0] ed, input logic [2:0] epc,
                     input logic [2:0] erc);
    vec_t v;
    v.name = nm; v.rst = r; v.req = rq; v.d0 = a; v.d1 = b; v.d2 = c; v.d3 = d;
    v.obusy = ob; v.e_ibusy = eb; v.e_oreq = eo; v.e_odata = ed; v.e_pc = epc; v.e_rc = erc;
    vecs.push_back(v);
  endtask

  function automatic logic [31:0] obs();
    return 32'({input_bussy, output_req, output_data, prio_count, reg_count});
  endfunction

  logic [15:0] np_in, nr_in, np_out, nr_out, exp_d;
  logic        acc_p, acc_r;

  initial begin
    // Reset and round robin across four regular senders.
    add("rst_state", 1, 4'b0101, 16'h0100, 16'h0111, 16'h0122, 16'h0133, 0, 4'b1111, 0, 16'h0000, 0, 0);
    add("rr_p0",     0, 4'b1111, 16'h0100, 16'h0111, 16'h0122, 16'h0133, 0, 4'b1110, 0, 16'h0000, 0, 0);
    add("rr_p1",     0, 4'b1111, 16'h0100, 16'h0111, 16'h0122, 16'h0133, 0, 4'b1101, 1, 16'h0100, 0, 1);
    add("rr_p2",     0, 4'b1111, 16'h0100, 16'h0111, 16'h0122, 16'h0133, 0, 4'b1011, 1, 16'h0111, 0, 1);
    add("rr_p3",     0, 4'b1111, 16'h0100, 16'h0111, 16'h0122, 16'h0133, 0, 4'b0111, 1, 16'h0122, 0, 1);
    add("rr_wrap0",  0, 4'b1111, 16'h0100, 16'h0111, 16'h0122, 16'h0133, 0, 4'b1110, 1, 16'h0133, 0, 1);
    add("rr_drain",  0, 4'b0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 4'b0000, 1, 16'h0100, 0, 1);
    add("idle_a",    0, 4'b0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 4'b0000, 0, 16'h0000, 0, 0);
    // Priority and regular flit arriving together.
    add("mix_push",  0, 4'b0110, 16'h0000, 16'h2AAA, 16'h0555, 16'h0000, 0, 4'b0000, 0, 16'h0000, 0, 0);
    add("mix_prio",  0, 4'b0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 4'b0000, 1, 16'h2AAA, 1, 1);
    add("mix_reg",   0, 4'b0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 4'b0000, 1, 16'h0555, 0, 1);
    add("idle_b",    0, 4'b0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 4'b0000, 0, 16'h0000, 0, 0);
    // Fill the regular FIFO under back-pressure, then push against a full FIFO.
    add("fill_1",    0, 4'b0001, 16'h0A01, 16'h0000, 16'h0000, 16'h0000, 1, 4'b0000, 0, 16'h0000, 0, 0);
    add("fill_2",    0, 4'b0001, 16'h0A02, 16'h0000, 16'h0000, 16'h0000, 1, 4'b0000, 1, 16'h0A01, 0, 1);
    add("fill_3",    0, 4'b0001, 16'h0A03, 16'h0000, 16'h0000, 16'h0000, 1, 4'b0000, 1, 16'h0A01, 0, 2);
    add("fill_4",    0, 4'b0001, 16'h0A04, 16'h0000, 16'h0000, 16'h0000, 1, 4'b0000, 1, 16'h0A01, 0, 3);
    add("full_stall",0, 4'b0001, 16'h0A05, 16'h0000, 16'h0000, 16'h0000, 1, 4'b0001, 1, 16'h0A01, 0, 4);
    add("full_pp",   0, 4'b0001, 16'h0A05, 16'h0000, 16'h0000, 16'h0000, 0, 4'b0001, 1, 16'h0A01, 0, 4);
    add("full_acc5", 0, 4'b0001, 16'h0A05, 16'h0000, 16'h0000, 16'h0000, 1, 4'b0000, 1, 16'h0A02, 0, 3);
    add("drain_2",   0, 4'b0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 4'b0000, 1, 16'h0A02, 0, 4);
    add("drain_3",   0, 4'b0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 4'b0000, 1, 16'h0A03, 0, 3);
    add("drain_4",   0, 4'b0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 4'b0000, 1, 16'h0A04, 0, 2);
    add("drain_5",   0, 4'b0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 4'b0000, 1, 16'h0A05, 0, 1);
    add("idle_c",    0, 4'b0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 4'b0000, 0, 16'h0000, 0, 0);

    drive(1, 4'b0000, 16'h0, 16'h0, 16'h0, 16'h0, 0);
    @(posedge clk); #1;

    foreach (vecs[k]) begin
      drive(vecs[k].rst, vecs[k].req, vecs[k].d0, vecs[k].d1, vecs[k].d2, vecs[k].d3, vecs[k].obusy);
      @(negedge clk);
      check(vecs[k].name, obs(),
            32'({vecs[k].e_ibusy, vecs[k].e_oreq, vecs[k].e_odata, vecs[k].e_pc, vecs[k].e_rc}));
      @(posedge clk); #1;
    end

    // Port 0 streams priority flits, port 1 regular flits: expect 4 prio, 1 reg.
    np_in = '0; nr_in = '0; np_out = '0; nr_out = '0;
    for (int j = 0; j < 26; j++) begin
      drive(0, 4'b0011, 16'h2000 + np_in, 16'h0800 + nr_in, 16'h0, 16'h0, 0);
      @(negedge clk);
      if (j == 0) begin
        check("starve_first_empty", 32'(output_req), 32'h0);
      end else begin
        if ((j - 1) % 5 == 4) begin
          exp_d  = 16'h0800 + nr_out;
          nr_out = nr_out + 1'b1;
        end else begin
          exp_d  = 16'h2000 + np_out;
          np_out = np_out + 1'b1;
        end
        check($sformatf("starve_out_%0d", j), 32'({output_req, output_data}), 32'({1'b1, exp_d}));
      end
      acc_p = !input_bussy[0];
      acc_r = !input_bussy[1];
      @(posedge clk); #1;
      if (acc_p) np_in = np_in + 1'b1;
      if (acc_r) nr_in = nr_in + 1'b1;
    end

    // Reset in the middle of traffic: nothing in flight may come out afterwards.
    drive(1, 4'b0000, 16'h0, 16'h0, 16'h0, 16'h0, 0);
    @(negedge clk);
    check("midop_reset_outputs", 32'({input_bussy, output_req}), 32'({4'b1111, 1'b0}));
    @(posedge clk); #1;
    drive(0, 4'b0000, 16'h0, 16'h0, 16'h0, 16'h0, 0);
    @(negedge clk);
    check("post_reset_empty", obs(), 32'h0);
    @(posedge clk); #1;

    // Three priority flits from port 2 leave the priority pointer at 2.
    for (int k = 0; k < 3; k++) begin
      drive(0, 4'b0100, 16'h0, 16'h0, 16'h2100 + 16'(k), 16'h0, 1);
      @(posedge clk); #1;
    end
    drive(1, 4'b1111, 16'h2200, 16'h2201, 16'h2202, 16'h2203, 0);
    @(negedge clk);
    check("reset_with_pc3", obs(), 32'({4'b1111, 1'b0, 16'h0000, 3'd3, 3'd0}));
    @(posedge clk); #1;
    drive(0, 4'b1111, 16'h2200, 16'h2201, 16'h2202, 16'h2203, 0);
    @(negedge clk);
    check("after_reset_rr_port0", obs(), 32'({4'b1110, 1'b0, 16'h0000, 3'd0, 3'd0}));
    @(posedge clk); #1;
    drive(0, 4'b0000, 16'h0, 16'h0, 16'h0, 16'h0, 0);
    @(negedge clk);
    check("after_reset_first_out", obs(), 32'({4'b0000, 1'b1, 16'h2200, 3'd1, 3'd0}));
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
